// File: rtl/hub75_pkg.sv
// Shared types and panel constants for the HUB75 scan driver.
package hub75_pkg;

    // Phases of one row-pair scan.
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } scan_state_t;

    // Default panel geometry and on-time.
    localparam int PANEL_COLS      = 64;
    localparam int PANEL_HALF_ROWS = 16;
    localparam int PANEL_ON_CYCLES = 64;

    // Fixed address widths seen by the pixel source and the panel.
    localparam int COL_W = 6;
    localparam int ROW_W = 4;

    // The six colour bits of one upper/lower pixel pair.
    typedef struct packed {
        logic r0;
        logic g0;
        logic b0;
        logic r1;
        logic g1;
        logic b1;
    } pixel_pair_t;

endpackage

// File: rtl/scan_counter.sv
// Up-counter that wraps to zero after LAST and flags the terminal value.
module scan_counter #(
    parameter int          WIDTH = 6,
    parameter int unsigned LAST  = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

    assign tc = (count == LAST_VAL);

    // Advance on enable, wrapping from LAST back to zero.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hub75_scan_driver.sv
// Scans a HUB75 panel one row pair at a time: shift, blank, latch, display.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int COLS      = PANEL_COLS,
    parameter int HALF_ROWS = PANEL_HALF_ROWS,
    parameter int ON_CYCLES = PANEL_ON_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    input  logic             R0,
    input  logic             G0,
    input  logic             B0,
    input  logic             R1,
    input  logic             G1,
    input  logic             B1,
    output logic             p_r0,
    output logic             p_g0,
    output logic             p_b0,
    output logic             p_r1,
    output logic             p_g1,
    output logic             p_b1,
    output logic             p_sclk,
    output logic             p_lat,
    output logic             p_oe_n,
    output logic [ROW_W-1:0] p_addr,
    output logic             frame_done
);

    localparam int ON_W = $clog2(ON_CYCLES + 1);

    scan_state_t state;
    scan_state_t state_next;

    // Shift phase: 0 = data set-up with sclk low, 1 = sclk high.
    logic ph;

    logic col_en;
    logic col_tc;
    logic row_en;
    logic row_tc;
    logic on_en;
    logic on_tc;
    logic [ON_W-1:0] on_count_unused;

    pixel_pair_t pix;
    pixel_pair_t pix_in;

    assign pix_in = '{r0: R0, g0: G0, b0: B0, r1: R1, g1: G1, b1: B1};

    // Column advances after the sclk-high half of each column.
    assign col_en = (state == SHIFT) && ph;
    // Row pair advances on the final cycle of its on-time.
    assign row_en = (state == DISPLAY) && on_tc;
    assign on_en  = (state == DISPLAY);

    scan_counter #(
        .WIDTH (COL_W),
        .LAST  (COLS - 1)
    ) u_col_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (col_en),
        .count (col),
        .tc    (col_tc)
    );

    scan_counter #(
        .WIDTH (ROW_W),
        .LAST  (HALF_ROWS - 1)
    ) u_row_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (row_en),
        .count (row),
        .tc    (row_tc)
    );

    // Only the terminal flag of the on-time counter drives the scan.
    scan_counter #(
        .WIDTH (ON_W),
        .LAST  (ON_CYCLES - 1)
    ) u_on_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (on_en),
        .count (on_count_unused),
        .tc    (on_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift phase toggles only while shifting and rests at 0 elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 1'b0;
        end else if (state == SHIFT) begin
            ph <= ~ph;
        end else begin
            ph <= 1'b0;
        end
    end

    // Capture the requested pixel pair at the end of the sclk-low half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix <= '0;
        end else if ((state == SHIFT) && !ph) begin
            pix <= pix_in;
        end
    end

    // Panel address follows the row pair just shifted, ahead of the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_addr <= '0;
        end else if (state == BLANK) begin
            p_addr <= row;
        end
    end

    // Next-state and panel strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_next = state;
        p_sclk     = 1'b0;
        p_lat      = 1'b0;
        p_oe_n     = 1'b1;
        frame_done = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                p_sclk = ph;
                if (ph && col_tc) begin
                    state_next = BLANK;
                end
            end
            BLANK: begin
                state_next = LATCH;
            end
            LATCH: begin
                p_lat      = 1'b1;
                state_next = DISPLAY;
            end
            DISPLAY: begin
                p_oe_n = 1'b0;
                if (on_tc) begin
                    frame_done = row_tc;
                    state_next = en ? SHIFT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign p_r0 = pix.r0;
    assign p_g0 = pix.g0;
    assign p_b0 = pix.b0;
    assign p_r1 = pix.r1;
    assign p_g1 = pix.g1;
    assign p_b1 = pix.b1;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: expected pixels and latched
// addresses are queued by the stimulus and consumed by a negedge monitor.
module tb_hub75_scan_driver;

    localparam int COLS       = 64;
    localparam int HALF_ROWS  = 16;
    localparam int ON_CYCLES  = 64;
    localparam int ROW_PERIOD = 194;
    localparam int FRAME_PERIOD = 3104;

    logic       clk;
    logic       rst;
    logic       en;
    logic [5:0] col;
    logic [3:0] row;
    logic       R0, G0, B0, R1, G1, B1;
    logic       p_r0, p_g0, p_b0, p_r1, p_g1, p_b1;
    logic       p_sclk;
    logic       p_lat;
    logic       p_oe_n;
    logic [3:0] p_addr;
    logic       frame_done;

    int mode;
    int n_checks;
    int n_fail;
    int cyc;

    // Scoreboard queues.
    logic [5:0] pix_q[$];
    logic [3:0] addr_q[$];

    // Monitor state.
    int         lat_count;
    int         frame_count;
    int         sclk_count;
    int         oe_low;
    int         last_lat;
    int         last_fd;
    bit         lat_seen;
    bit         lat_steady;
    bit         fd_seen;
    bit         fd_steady;
    logic       sclk_q;
    logic       fd_q;
    logic [5:0] d_at_sclk;

    hub75_scan_driver #(
        .COLS      (COLS),
        .HALF_ROWS (HALF_ROWS),
        .ON_CYCLES (ON_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .col        (col),
        .row        (row),
        .R0         (R0),
        .G0         (G0),
        .B0         (B0),
        .R1         (R1),
        .G1         (G1),
        .B1         (B1),
        .p_r0       (p_r0),
        .p_g0       (p_g0),
        .p_b0       (p_b0),
        .p_r1       (p_r1),
        .p_g1       (p_g1),
        .p_b1       (p_b1),
        .p_sclk     (p_sclk),
        .p_lat      (p_lat),
        .p_oe_n     (p_oe_n),
        .p_addr     (p_addr),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel source patterns, bit order {r0,g0,b0,r1,g1,b1}.
    function automatic logic [5:0] pix_fn(input int m, input int c, input int r);
        logic [5:0] cv;
        logic [3:0] rv;
        cv = 6'(c);
        rv = 4'(r);
        case (m)
            0:       return (c == 5) ? 6'b100000 : 6'b000000;
            1:       return 6'b111111;
            default: return {cv[0], cv[1] ^ rv[0], cv[2], ~cv[0], cv[5], rv[0]};
        endcase
    endfunction

    always_comb begin
        {R0, G0, B0, R1, G1, B1} = pix_fn(mode, int'(col), int'(row));
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_row(input int m, input int r);
        for (int c = 0; c < COLS; c++) pix_q.push_back(pix_fn(m, c, r));
        addr_q.push_back(4'(r));
    endtask

    task automatic wait_lats(input int n, input int budget);
        int k;
        k = 0;
        while (lat_count < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("wait_lat", lat_count, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col"}, col, 0);
        check({tag, "_row"}, row, 0);
        check({tag, "_data"}, {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1}, 0);
        check({tag, "_sclk"}, p_sclk, 0);
        check({tag, "_lat"}, p_lat, 0);
        check({tag, "_oe_n"}, p_oe_n, 1);
        check({tag, "_addr"}, p_addr, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    // Monitor: consumes expectations whenever the panel is clocked or latched.
    always @(negedge clk) begin
        logic [5:0] d;
        d = {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1};
        if (rst) begin
            sclk_q     = 1'b0;
            fd_q       = 1'b0;
            sclk_count = 0;
            oe_low     = 0;
            lat_seen   = 1'b0;
            lat_steady = 1'b0;
            fd_seen    = 1'b0;
            fd_steady  = 1'b0;
        end else begin
            if (!en) begin
                lat_steady = 1'b0;
                fd_steady  = 1'b0;
            end
            if (p_sclk && !sclk_q) begin
                check("pix_avail", int'(pix_q.size() != 0), 1);
                if (pix_q.size() != 0) check("pixel", d, pix_q.pop_front());
                sclk_count++;
                d_at_sclk = d;
            end
            if (sclk_q && !p_sclk) check("data_hold", d, d_at_sclk);
            if (p_lat) begin
                check("oe_off_at_lat", p_oe_n, 1);
                check("sclk_per_row", sclk_count, COLS);
                check("addr_avail", int'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) check("lat_addr", p_addr, addr_q.pop_front());
                if (lat_seen) check("oe_low_cycles", oe_low, ON_CYCLES);
                if (lat_seen && lat_steady) check("row_period", cyc - last_lat, ROW_PERIOD);
                lat_seen   = 1'b1;
                lat_steady = en;
                last_lat   = cyc;
                sclk_count = 0;
                oe_low     = 0;
                lat_count++;
            end
            if (!p_oe_n) oe_low++;
            if (fd_q) check("oe_off_after_frame", p_oe_n, 1);
            if (frame_done) begin
                check("fd_single", fd_q, 0);
                check("fd_in_display", p_oe_n, 0);
                check("fd_last_row", p_addr, HALF_ROWS - 1);
                if (fd_seen && fd_steady) check("frame_period", cyc - last_fd, FRAME_PERIOD);
                fd_seen   = 1'b1;
                fd_steady = en;
                last_fd   = cyc;
                frame_count++;
            end
            sclk_q = p_sclk;
            fd_q   = frame_done;
        end
    end

    initial begin
        bit idle_dark;
        n_checks    = 0;
        n_fail      = 0;
        cyc         = 0;
        lat_count   = 0;
        frame_count = 0;
        mode        = 0;
        rst         = 1'b1;
        en          = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // Two full frames plus rows 0..3, single lit pixel at column 5.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < HALF_ROWS; r++) push_row(0, r);
        for (int r = 0; r < 4; r++) push_row(0, r);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        wait_lats(33, 33 * ROW_PERIOD + 300);
        check("frames_after_two", frame_count, 2);

        // Drop en while row 3 is shifting; row 3 must still latch and display.
        wait_lats(35, 2 * ROW_PERIOD + 50);
        repeat (85) @(negedge clk);
        check("shifting_row3", row, 3);
        en = 1'b0;
        wait_lats(36, 300);
        repeat (80) @(negedge clk);
        idle_dark = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (p_oe_n !== 1'b1 || p_sclk !== 1'b0 || p_lat !== 1'b0) idle_dark = 1'b0;
        end
        check("idle_dark", idle_dark, 1);
        check("idle_row_next", row, 4);
        check("idle_col", col, 0);
        check("idle_lat_count", lat_count, 36);

        // Resume with all six bits set; scan continues at row 4.
        mode = 1;
        for (int r = 4; r < 10; r++) push_row(1, r);
        @(negedge clk);
        en = 1'b1;
        wait_lats(42, 6 * ROW_PERIOD + 300);

        // Asynchronous reset in the middle of row 9's on-time.
        repeat (30) @(negedge clk);
        check("mid_display_oe", p_oe_n, 0);
        check("mid_display_addr", p_addr, 9);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        check("pix_q_drained", pix_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);

        // After release the scan restarts at row 0.
        mode = 2;
        push_row(2, 0);
        push_row(2, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_lats(44, 2 * ROW_PERIOD + 300);
        @(negedge clk);
        en = 1'b0;
        repeat (100) @(negedge clk);
        check("final_pix_q", pix_q.size(), 0);
        check("final_addr_q", addr_q.size(), 0);
        check("final_oe_n", p_oe_n, 1);
        check("final_lat_count", lat_count, 44);
        check("final_row", row, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
